hex_scan_ctrl: RTL and testbench
================================

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000: clock cycles each digit is shown; legal range 1..2^20.
REQ-002 Port clk  input  1  rising-edge clock for all logic.
REQ-003 Port reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-004 Port en  input  1  scan enable; 0 blanks the display.
REQ-005 Port upd_valid  input  1  new display value offered.
REQ-006 Port upd_data  input  16  four hex nibbles; [3:0] is digit 0 (rightmost).
REQ-007 Port upd_ready  output  1  update buffer can accept a value.
REQ-008 Port seg  output  7  active-low segment drive, bit0=a .. bit6=g.
REQ-009 Port an  output  4  active-low one-hot digit enable.
REQ-010 Port frame_done  output  1  one-cycle pulse when digit 3 finishes its slot.

Function
REQ-011 One shared hex_decoder SHALL be time-multiplexed over 4 digits; digit order 0,1,2,3,0 (wrap).
REQ-012 States SHALL be IDLE, SHOW, GAP.
- IDLE->SHOW (idx=0) when en=1.
- SHOW lasts exactly TICK_DIV cycles, then ->GAP.
- GAP lasts 1 cycle, increments idx mod 4, then ->SHOW.
- Any state ->IDLE when en=0; idx and prescaler cleared.
REQ-013 In SHOW, an SHALL equal ~(1<<idx) and seg SHALL equal the decode of shadow nibble idx; in IDLE and GAP, an=4'hF and seg=7'h7F.
REQ-014 seg/an SHALL be registered: outputs in cycle t+1 reflect state/idx in cycle t.
REQ-015 frame_done SHALL pulse for 1 cycle in the GAP cycle that follows digit 3's SHOW.
REQ-016 Transfer occurs when upd_valid&&upd_ready; data goes to a pending buffer; upd_ready SHALL be 0 from the next cycle while pending is full.
REQ-017 Pending SHALL copy to shadow only at a frame boundary (the frame_done GAP cycle) or in any IDLE cycle; upd_ready returns to 1 the following cycle.
REQ-018 Transfer and boundary in the same cycle: the boundary SHALL use the prior pending contents only; the new data stays pending for the next boundary.
REQ-019 Shadow SHALL NOT change mid-frame (no tearing).
REQ-020 TICK_DIV=1: SHOW lasts 1 cycle; the sequence stays SHOW,GAP alternating.
REQ-021 en deasserted mid-SHOW: outputs blank next cycle, no frame_done; re-enable starts at digit 0 with a full TICK_DIV slot.

Reset
REQ-022 While reset=1: state=IDLE, idx=0, prescaler=0, shadow=16'h0000, pending empty, seg=7'h7F, an=4'hF, upd_ready=1, frame_done=0.
REQ-023 Reset SHALL override en and upd_valid; a transfer presented with reset=1 is discarded.

Configuration
REQ-024 Macro HEX_SCAN_LZB_EN defined: leading-zero blanking -- digits 3..1 whose nibble and all higher nibbles are 0 show seg=7'h7F with an still active; digit 0 is never blanked.
REQ-025 HEX_SCAN_LZB_EN undefined: all four digits always decoded; no blanking logic present.

Structure
REQ-026 Package hex_scan_pkg SHALL hold the state enum, NUM_DIGITS=4, and SEG_OFF=7'h7F.
REQ-027 hex_scan_ctrl SHALL instantiate exactly one hex_decoder (4-bit in, 7-bit active-low out) as its only sub-module.

Verification (TICK_DIV=4)
REQ-028 Reset, then en=1, shadow=0 -> an sequence E,F,D,F,B,F,7,F; each E/D/B/7 held 4 cycles; seg=7'h40 in each slot.
REQ-029 Transfer 16'h1234 mid-frame -> upd_ready=0 next cycle; current frame still shows 0000; next frame digits 0..3 show seg 7'h19, 7'h30, 7'h24, 7'h79; upd_ready=1 after the boundary.
REQ-030 Transfer on the frame_done cycle with 16'hABCD pending 16'h0001 -> next frame shows 0001, following frame shows ABCD.
REQ-031 en=0 during digit 2's SHOW -> an=F, seg=7F next cycle, no frame_done; en=1 -> digit 0 held 4 cycles.
REQ-032 HEX_SCAN_LZB_EN, value 16'h0050 -> digits 3,2 seg=7'h7F, digit 1 seg=7'h12, digit 0 seg=7'h40; without macro, digits 3,2 seg=7'h40.
REQ-033 reset asserted mid-SHOW with pending full -> next cycle all REQ-022 values; the pending value is never displayed.

Source files
------------

// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the four-digit multiplexed hex display scanner.
package hex_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;

endpackage

// File: rtl/hex_decoder.sv
// Hex nibble to active-low seven-segment pattern, bit0 = segment a .. bit6 = segment g.
module hex_decoder (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (nib_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Four-digit time-multiplexed hex display scanner with a double-buffered update port.
// Optional leading-zero blanking is compiled in when HEX_SCAN_LZB_EN is defined.
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    output logic        upd_ready,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done,
    output state_t      state_dbg
);

    localparam int unsigned      CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [1:0]       IDX_LAST = 2'(NUM_DIGITS - 1);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic             frame_end;
    logic             xfer;
    logic             copy;
    logic [3:0]       cur_nib;
    logic [6:0]       dec_seg;
    logic             lz_blank;

    // Scan FSM: IDLE until enabled, then SHOW for TICK_DIV cycles and a
    // single blank GAP cycle per digit. Dropping en returns to IDLE at once.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        presc_d = presc_q;
        if (!en) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SHOW;
                    idx_d   = 2'd0;
                    presc_d = '0;
                end
                ST_SHOW: begin
                    if (presc_q == CNT_LAST) begin
                        state_d = ST_GAP;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    state_d = ST_SHOW;
                    idx_d   = idx_q + 2'd1;
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                    presc_d = '0;
                end
            endcase
        end
    end

    assign frame_end = !reset && en && (state_q == ST_GAP) && (idx_q == IDX_LAST);

    // Update handshake: a value transfers on a cycle where upd_valid and
    // upd_ready are both high. upd_ready is registered (inverse of the
    // pending-full flag), so it never depends combinationally on upd_valid.
    // The pending value moves to the shadow only at a frame boundary or
    // while idle, so the digits of one frame always come from one value.
    assign xfer = upd_valid && !pend_full_q;
    assign copy = pend_full_q && ((state_q == ST_IDLE) || frame_end);

    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        shadow_d    = shadow_q;
        if (xfer) begin
            pend_d      = upd_data;
            pend_full_d = 1'b1;
        end else if (copy) begin
            shadow_d    = pend_q;
            pend_full_d = 1'b0;
        end
    end

    assign cur_nib = shadow_q[{idx_q, 2'b00} +: 4];

    hex_decoder u_dec (
        .nib_i (cur_nib),
        .seg_o (dec_seg)
    );

`ifdef HEX_SCAN_LZB_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        lz_blank = 1'b0;
        case (idx_q)
            2'd1:    lz_blank = (shadow_q[15:4] == 12'h000);
            2'd2:    lz_blank = (shadow_q[15:8] == 8'h00);
            2'd3:    lz_blank = (shadow_q[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        seg_d = SEG_OFF;
        an_d  = 4'hF;
        if (en && (state_q == ST_SHOW)) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = lz_blank ? SEG_OFF : dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            presc_q     <= '0;
            shadow_q    <= 16'h0000;
            pend_q      <= 16'h0000;
            pend_full_q <= 1'b0;
            seg_q       <= SEG_OFF;
            an_q        <= 4'hF;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            presc_q     <= presc_d;
            shadow_q    <= shadow_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign upd_ready  = !pend_full_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_end;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl (TICK_DIV=4): frame-position reference model checked every
// cycle, plus directed scenarios with hand-computed expectations and a random phase.
module tb_hex_scan_ctrl;
    import hex_scan_pkg::*;

    localparam int T  = 4;
    localparam int FR = 4 * (T + 1);

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic        upd_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
    state_t      state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    hex_scan_ctrl #(.TICK_DIV(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .upd_valid  (upd_valid),
        .upd_data   (upd_data),
        .upd_ready  (upd_ready),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        m_valid = 1'b0;
    logic        m_run;
    int          m_p;
    logic [15:0] m_shadow;
    logic [15:0] m_pend;
    logic        m_full;
    logic [6:0]  m_seg;
    logic [3:0]  m_an;
    logic        fd_exp;
    logic        show;
    int          dig;

    function automatic logic [6:0] model_seg(input logic [15:0] sh, input int d);
        logic [15:0] hi;
        hi = sh >> (4 * d);
`ifdef HEX_SCAN_LZB_EN
        if (d > 0 && hi == 16'h0000) return 7'h7F;
`endif
        return font[hi[3:0]];
    endfunction

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard: inputs change at negedge; outputs are compared 2 ns later and
    // the model then advances with the inputs the next posedge will sample.
    always begin
        @(negedge clk);
        #2;
        cyc++;
        fd_exp = !reset && en && m_valid && m_run && (m_p == FR - 1);
        if (m_valid) begin
            pin("model_seg", 32'(seg), 32'(m_seg));
            pin("model_an", 32'(an), 32'(m_an));
            pin("model_ready", 32'(upd_ready), 32'(!m_full));
            pin("model_frame_done", 32'(frame_done), 32'(fd_exp));
        end
        if (reset) begin
            m_valid  = 1'b1;
            m_run    = 1'b0;
            m_p      = 0;
            m_shadow = 16'h0000;
            m_pend   = 16'h0000;
            m_full   = 1'b0;
            m_seg    = 7'h7F;
            m_an     = 4'hF;
        end else if (m_valid) begin
            show = m_run && ((m_p % (T + 1)) < T);
            dig  = m_p / (T + 1);
            if (en && show) begin
                m_an  = ~(4'b0001 << dig);
                m_seg = model_seg(m_shadow, dig);
            end else begin
                m_an  = 4'hF;
                m_seg = 7'h7F;
            end
            if (upd_valid && !m_full) begin
                m_pend = upd_data;
                m_full = 1'b1;
            end else if (m_full && (!m_run || fd_exp)) begin
                m_shadow = m_pend;
                m_full   = 1'b0;
            end
            if (!en) begin
                m_run = 1'b0;
                m_p   = 0;
            end else if (!m_run) begin
                m_run = 1'b1;
                m_p   = 0;
            end else begin
                m_p = (m_p + 1) % FR;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic adv(input int n);
        repeat (n) step();
        #1;
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            step();
            #1;
            n++;
        end while (frame_done !== 1'b1 && n < 60);
        pin("frame_done_seen", 32'(frame_done), 32'd1);
    endtask

    logic [3:0] an_tbl [22] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hF,
                                4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE};
    logic [6:0] lz_seg;

    initial begin
`ifdef HEX_SCAN_LZB_EN
        lz_seg = 7'h7F;
`else
        lz_seg = 7'h40;
`endif
        reset     = 1'b1;
        en        = 1'b0;
        upd_valid = 1'b0;
        upd_data  = 16'h0000;
        repeat (3) step();
        #1;
        pin("rst_ready", 32'(upd_ready), 32'd1);
        pin("rst_an", 32'(an), 32'hF);
        pin("rst_seg", 32'(seg), 32'h7F);
        pin("rst_frame_done", 32'(frame_done), 32'd0);
        pin("rst_state", 32'(state_dbg), 32'(ST_IDLE));

        // Scan order and slot lengths with an all-zero shadow.
        step();
        reset = 1'b0;
        en    = 1'b1;
        #1;
        for (int k = 1; k <= 22; k++) begin
            adv(1);
            pin("scan_an", 32'(an), 32'(an_tbl[k-1]));
            pin("scan_seg", 32'(seg), (an_tbl[k-1] != 4'hF) ? 32'h40 : 32'h7F);
            pin("scan_frame_done", 32'(frame_done), (k == 20) ? 32'd1 : 32'd0);
        end

        // Mid-frame update 1234 appears from the next frame only.
        step();
        upd_valid = 1'b1;
        upd_data  = 16'h1234;
        #1;
        pin("upd_ready_before", 32'(upd_ready), 32'd1);
        step();
        upd_valid = 1'b0;
        #1;
        pin("upd_ready_pending", 32'(upd_ready), 32'd0);
        wait_fd();
        adv(1);
        pin("upd_ready_after_boundary", 32'(upd_ready), 32'd1);
        pin("gap_an", 32'(an), 32'hF);
        adv(1);
        pin("f1234_d0_an", 32'(an), 32'hE);
        pin("f1234_d0_seg", 32'(seg), 32'h19);
        adv(5);
        pin("f1234_d1_an", 32'(an), 32'hD);
        pin("f1234_d1_seg", 32'(seg), 32'h30);
        adv(5);
        pin("f1234_d2_an", 32'(an), 32'hB);
        pin("f1234_d2_seg", 32'(seg), 32'h24);
        adv(5);
        pin("f1234_d3_an", 32'(an), 32'h7);
        pin("f1234_d3_seg", 32'(seg), 32'h79);

        // 0001 pending while ABCD is offered across the boundary.
        step();
        upd_valid = 1'b1;
        upd_data  = 16'h0001;
        #1;
        pin("p0001_ready", 32'(upd_ready), 32'd1);
        step();
        upd_data = 16'hABCD;
        #1;
        pin("p0001_held", 32'(upd_ready), 32'd0);
        wait_fd();
        pin("boundary_ready", 32'(upd_ready), 32'd0);
        adv(1);
        pin("abcd_accept_ready", 32'(upd_ready), 32'd1);
        step();
        upd_valid = 1'b0;
        #1;
        pin("abcd_pending", 32'(upd_ready), 32'd0);
        pin("f0001_d0_an", 32'(an), 32'hE);
        pin("f0001_d0_seg", 32'(seg), 32'h79);
        adv(5);
        pin("f0001_d1_seg", 32'(seg), 32'h40);
        wait_fd();
        adv(2);
        pin("fabcd_ready", 32'(upd_ready), 32'd1);
        pin("fabcd_d0_seg", 32'(seg), 32'h21);
        adv(15);
        pin("fabcd_d3_an", 32'(an), 32'h7);
        pin("fabcd_d3_seg", 32'(seg), 32'h08);

        // en dropped during digit 2.
        begin
            int n;
            n = 0;
            do begin
                adv(1);
                n++;
            end while (an !== 4'hB && n < 40);
            pin("digit2_reached", 32'(an), 32'hB);
        end
        step();
        en = 1'b0;
        #1;
        adv(1);
        pin("dis_an", 32'(an), 32'hF);
        pin("dis_seg", 32'(seg), 32'h7F);
        pin("dis_frame_done", 32'(frame_done), 32'd0);
        adv(1);
        pin("dis_frame_done2", 32'(frame_done), 32'd0);
        step();
        en = 1'b1;
        #1;
        pin("reen_s0_an", 32'(an), 32'hF);
        adv(1);
        pin("reen_s1_an", 32'(an), 32'hF);
        for (int k = 0; k < 4; k++) begin
            adv(1);
            pin("reen_d0_an", 32'(an), 32'hE);
            pin("reen_d0_seg", 32'(seg), 32'h21);
        end
        adv(1);
        pin("reen_gap_an", 32'(an), 32'hF);

        // Load 0050 while idle; leading-zero digits depend on the build.
        step();
        en        = 1'b0;
        upd_valid = 1'b1;
        upd_data  = 16'h0050;
        #1;
        pin("idle_load_ready", 32'(upd_ready), 32'd1);
        step();
        upd_valid = 1'b0;
        #1;
        pin("idle_load_pending", 32'(upd_ready), 32'd0);
        step();
        en = 1'b1;
        #1;
        pin("idle_copy_ready", 32'(upd_ready), 32'd1);
        adv(2);
        pin("lz_d0_an", 32'(an), 32'hE);
        pin("lz_d0_seg", 32'(seg), 32'h40);
        adv(5);
        pin("lz_d1_seg", 32'(seg), 32'h12);
        adv(5);
        pin("lz_d2_an", 32'(an), 32'hB);
        pin("lz_d2_seg", 32'(seg), 32'(lz_seg));
        adv(5);
        pin("lz_d3_an", 32'(an), 32'h7);
        pin("lz_d3_seg", 32'(seg), 32'(lz_seg));

        // Reset mid-SHOW with a full pending buffer.
        step();
        upd_valid = 1'b1;
        upd_data  = 16'hFFFF;
        #1;
        pin("pre_rst_ready", 32'(upd_ready), 32'd1);
        step();
        upd_valid = 1'b0;
        reset     = 1'b1;
        #1;
        pin("pre_rst_pending", 32'(upd_ready), 32'd0);
        pin("in_rst_frame_done", 32'(frame_done), 32'd0);
        adv(1);
        pin("mid_rst_an", 32'(an), 32'hF);
        pin("mid_rst_seg", 32'(seg), 32'h7F);
        pin("mid_rst_ready", 32'(upd_ready), 32'd1);
        pin("mid_rst_frame_done", 32'(frame_done), 32'd0);
        step();
        reset = 1'b0;
        #1;
        adv(2);
        pin("post_rst_d0_an", 32'(an), 32'hE);
        pin("post_rst_d0_seg", 32'(seg), 32'h40);
        adv(5);
        pin("post_rst_d1_seg", 32'(seg), 32'h40);

        // Random traffic checked by the model alone.
        for (int i = 0; i < 1500; i++) begin
            step();
            reset     = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            upd_valid = ($urandom_range(0, 2) == 0);
            upd_data  = 16'($urandom);
        end
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
